// File: rtl/vga_timing_gen_pkg.sv
// Shared coordinate type, sync bundle and 640x480@60 raster defaults used by
// the VGA timing generator and its consumers.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;

  localparam int H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int MAX_TOTAL = 1024;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

  // Idle raster level: both syncs released, nothing visible.
  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

  function automatic logic in_span(coord_t c, int lo, int hi);
    int v;
    v = {22'd0, c};
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_pipe.sv
// Enable-gated shift register that delays the sync/blank bundle by DEPTH
// pixel ticks; DEPTH=0 is a straight wire.
module vga_sync_pipe #(
  parameter int               DEPTH     = 1,
  parameter int               WIDTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = ^{Clk, Reset, en};
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge Clk) begin
        if (Reset) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
        end else if (en) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel-enable divider, scan counters, sync/blank decode
// and a pixel-delayed sync copy lined up with the registered colour output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int H_VISIBLE  = VGA_H_VISIBLE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_VISIBLE  = VGA_V_VISIBLE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int PIPE_DELAY = 1
) (
  input  logic   Clk,
  input  logic   Reset,
  output logic   pixel_ce,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   blank,
  output logic   hs,
  output logic   vs,
  output logic   hs_d,
  output logic   vs_d,
  output logic   blank_d,
  output logic   line_start,
  output logic   frame_start
);

  localparam int H_TOT    = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VISIBLE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam coord_t H_LAST = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST = coord_t'(V_TOT - 1);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  generate
    if (H_TOT > MAX_TOTAL || V_TOT > MAX_TOTAL) begin : g_bad_total
      $error("vga_timing_gen: raster totals must not exceed 1024");
    end
    if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_pipe
      $error("vga_timing_gen: PIPE_DELAY must be 0..4");
    end
  endgenerate

  logic [DIV_W-1:0] div_cnt;
  coord_t           x_next;
  coord_t           y_next;
  logic             x_wrap;
  logic             y_wrap;
  sync_t            sync_now;
  sync_t            sync_dly;

  // Pixel-enable divider; the strobe is masked while Reset is held.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign pixel_ce = (div_cnt == DIV_LAST) && !Reset;

  assign x_wrap = (DrawX == H_LAST);
  assign y_wrap = (DrawY == V_LAST);

  always_comb begin
    x_next = x_wrap ? '0 : DrawX + 1'b1;
    y_next = DrawY;
    if (x_wrap) begin
      y_next = y_wrap ? '0 : DrawY + 1'b1;
    end
  end

  // Sync and blank decode from the next position so they change in the same
  // edge as the counters and never lag DrawX/DrawY.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      DrawX <= '0;
      DrawY <= '0;
      hs    <= SYNC_IDLE.hs;
      vs    <= SYNC_IDLE.vs;
      blank <= SYNC_IDLE.blank;
    end else if (pixel_ce) begin
      DrawX <= x_next;
      DrawY <= y_next;
      hs    <= !in_span(x_next, HS_START, HS_END);
      vs    <= !in_span(y_next, VS_START, VS_END);
      blank <= in_span(x_next, 0, H_VISIBLE) && in_span(y_next, 0, V_VISIBLE);
    end
  end

  assign line_start  = pixel_ce && x_wrap;
  assign frame_start = line_start && y_wrap;

  assign sync_now = '{hs: hs, vs: vs, blank: blank};

  vga_sync_pipe #(
    .DEPTH     (PIPE_DELAY),
    .WIDTH     ($bits(sync_t)),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_pipe (
    .Clk   (Clk),
    .Reset (Reset),
    .en    (pixel_ce),
    .din   (sync_now),
    .dout  (sync_dly)
  );

  assign hs_d    = sync_dly.hs;
  assign vs_d    = sync_dly.vs;
  assign blank_d = sync_dly.blank;

endmodule
